// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic inter-stage pipeline register with a valid/ready handshake.
// SKID=1 gives a 2-entry skid buffer with a registered in_ready; SKID=0 gives a
// single entry whose in_ready is derived combinationally from out_ready.
// During bubbles the held slot carries the upstream PC and delay-slot flag, so
// CP0 always sees a meaningful PC. Exception requests load EXC_VECTOR; flushes
// clear the PC to zero.

module pipe_stage_buf #(
    parameter int unsigned     DATA_W     = 64,
    parameter int unsigned     PC_W       = 32,
    parameter int unsigned     EXC_W      = 5,
    parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_4180,
    parameter bit              SKID       = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_ds,
    input  logic [EXC_W-1:0]  in_exc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ds,
    output logic [EXC_W-1:0]  out_exc,
    output logic [1:0]        occupancy
);

    // The encoding equals the number of valid entries held, so occupancy is
    // the state register itself and can never disagree with it.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
        logic              ds;
        logic [EXC_W-1:0]  exc;
    } entry_t;

    state_e state_q, state_d;
    entry_t main_q,  main_d;     // entry presented on out_*
    entry_t skid_q,  skid_d;     // second entry, meaningful only in ST_TWO
    logic   in_ready_q, in_ready_d;

    entry_t in_entry;
    entry_t bubble_entry;
    logic   in_xfer;
    logic   out_xfer;

    // Upstream entry as offered, and the bubble that replaces it when nothing is
    // captured: the PC and delay-slot flag survive, payload and exception are zeroed.
    assign in_entry     = '{pc: in_pc, data: in_data, ds: in_ds, exc: in_exc};
    assign bubble_entry = '{pc: in_pc, data: '0, ds: in_ds, exc: '0};

    assign out_valid = (state_q != ST_EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // With a skid buffer in_ready comes straight from a flop, which breaks the
    // out_ready -> in_ready timing path; without it the stage can only accept
    // when it is empty or is being drained in the same cycle.
    generate
        if (SKID) begin : g_skid_ready
            assign in_ready = in_ready_q;
        end else begin : g_comb_ready
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    assign out_pc    = main_q.pc;
    assign out_data  = main_q.data;
    assign out_ds    = main_q.ds;
    assign out_exc   = main_q.exc;
    assign occupancy = state_q;

    // Next-state and next-entry selection: req beats flush beats the handshake.
    always_comb begin
        // NOTE: every signal driven here is given its hold value first, so no
        // path through the case/if tree can leave one unassigned and infer a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (req) begin
            // Exception redirect: drop everything, including an upstream entry
            // offered this cycle, and present the vector PC as a bubble.
            state_d   = ST_EMPTY;
            main_d    = '0;
            main_d.pc = EXC_VECTOR;
            skid_d    = '0;
        end else if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d = ST_ONE;
                        main_d  = in_entry;
                    end else begin
                        main_d  = bubble_entry;
                    end
                end

                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d  = in_entry;
                    end else if (in_xfer && SKID) begin
                        // Downstream stalled: main must stay put, so park the
                        // newcomer in the skid slot.
                        state_d = ST_TWO;
                        skid_d  = in_entry;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                        main_d  = bubble_entry;
                    end
                end

                ST_TWO: begin
                    // in_ready is low here, so the only event is a drain; the
                    // skid entry moves up behind the one just consumed.
                    if (out_xfer) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end

                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end

        in_ready_d = (state_d != ST_TWO);
    end

    // State, entries and registered in_ready, all cleared by asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the entry storage is reset, not just the state, because out_data,
            // out_pc and out_exc must read zero while reset is asserted.
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values,
            // independent of statement order.
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule
